// File: rtl/enet_tx_sched.sv
// Ethernet TX descriptor scheduler: queues frame lengths, writes each to the MAC
// over a single-beat bus, waits for the transmitter, and enforces an inter-frame gap.
module enet_tx_sched #(
  parameter int DEPTH      = 4,
  parameter int GAP_CYCLES = 24,
  parameter int TIMEOUT    = 65535
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        desc_valid_i,
  input  logic [11:0] desc_len_i,
  output logic        desc_ready_o,
  output logic [12:0] m_adr_o,
  output logic [31:0] m_dat_o,
  output logic [3:0]  m_sel_o,
  output logic        m_stb_o,
  output logic        m_we_o,
  input  logic        m_ack_i,
  input  logic        txempty_i,
  output logic        busy_o,
  output logic [4:0]  count_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [15:0] BUSY_LAST = 16'd15;
  localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);
  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT);
  localparam logic [4:0]  FULL_CNT  = 5'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [11:0]        len_q, len_d;
  logic [11:0]        mem_q [DEPTH];
  logic [11:0]        mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [4:0]         count_q, count_d;

  logic        fifo_full;
  logic        fifo_empty;
  logic        push;
  logic        pop;
  logic [11:0] head;

  assign fifo_full  = (count_q == FULL_CNT);
  assign fifo_empty = (count_q == 5'd0);
  assign push       = desc_valid_i & ~fifo_full;
  assign pop        = (state_q == S_IDLE) & ~fifo_empty;
  assign head       = mem_q[rd_ptr_q];

  // Descriptor FIFO; a full FIFO refuses pushes even if a pop happens that cycle.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = desc_len_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      len_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Next-state logic; cnt restarts from zero on every state change.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    len_d   = len_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!fifo_empty) begin
          len_d   = head;
          state_d = (head == 12'd0) ? S_GAP : S_START;
        end
      end
      S_START: begin
        cnt_d = '0;
        if (m_ack_i) state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        // A short frame may finish before txempty is ever seen low.
        if (!txempty_i || cnt_q == BUSY_LAST) begin
          state_d = S_WAIT_DONE;
          cnt_d   = '0;
        end
      end
      S_WAIT_DONE: begin
        if (txempty_i || cnt_q == TMO_LAST) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs; done/err fire in the cycle that commits the move into GAP.
  always_comb begin
    m_adr_o = '0;
    m_dat_o = '0;
    m_sel_o = '0;
    m_stb_o = 1'b0;
    m_we_o  = 1'b0;
    done_o  = 1'b0;
    err_o   = 1'b0;
    busy_o  = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        done_o = ~fifo_empty & (head == 12'd0);
      end
      S_START: begin
        m_stb_o = 1'b1;
        m_we_o  = 1'b1;
        m_sel_o = 4'hF;
        m_dat_o = {20'b0, len_q};
      end
      S_WAIT_DONE: begin
        done_o = txempty_i;
        err_o  = ~txempty_i & (cnt_q == TMO_LAST);
      end
      default: begin
      end
    endcase
  end

  assign desc_ready_o = ~fifo_full;
  assign count_o      = count_q;

endmodule

// File: doc/enet_tx_sched.md
ENET_TX_SCHED -- requirements
Module: enet_tx_sched

Interface
REQ-001 SHALL have parameter DEPTH, default 4, descriptor FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter GAP_CYCLES, default 24, clk_i cycles of idle enforced between frames (1..255).
REQ-003 SHALL have parameter TIMEOUT, default 65535, max clk_i cycles in WAIT_DONE before abort (16-bit).
REQ-004 clk_i  input  1  single clock; all logic on rising edge.
REQ-005 rst_i  input  1  reset, asynchronous, active-high.
REQ-006 desc_valid_i  input  1  host offers a frame length.
REQ-007 desc_len_i  input  12  frame length in bytes.
REQ-008 desc_ready_o  output  1  FIFO not full; push occurs when desc_valid_i & desc_ready_o.
REQ-009 m_adr_o  output  13  MAC bus address.
REQ-010 m_dat_o  output  32  MAC bus write data.
REQ-011 m_sel_o  output  4  byte selects.
REQ-012 m_stb_o  output  1  MAC bus strobe.
REQ-013 m_we_o  output  1  MAC bus write enable.
REQ-014 m_ack_i  input  1  MAC bus acknowledge.
REQ-015 txempty_i  input  1  MAC interrupt, high while MAC transmitter idle.
REQ-016 busy_o  output  1  state not IDLE.
REQ-017 count_o  output  5  descriptors queued, excluding the one in flight.
REQ-018 done_o  output  1  one-cycle pulse, frame completed normally.
REQ-019 err_o  output  1  one-cycle pulse, frame aborted by timeout.

Function
REQ-020 SHALL hold descriptors in a DEPTH-entry FIFO; push and pop in same cycle SHALL leave count unchanged; push when full SHALL be impossible (desc_ready_o low).
REQ-021 SHALL implement states IDLE, START, WAIT_BUSY, WAIT_DONE, GAP.
REQ-022 IDLE: if FIFO non-empty, pop head into len register and go START next cycle.
REQ-023 START: drive m_stb_o=1, m_we_o=1, m_adr_o=0, m_sel_o=4'hF, m_dat_o={20'b0,len}; hold all stable until m_ack_i; on ack deassert m_stb_o next cycle, go WAIT_BUSY.
REQ-024 len=0 SHALL skip bus write: IDLE->GAP directly, with done_o pulsed on entering GAP.
REQ-025 WAIT_BUSY: go WAIT_DONE when txempty_i low, or after 16 cycles regardless (MAC may finish short frame before sampling).
REQ-026 WAIT_DONE: on txempty_i high, pulse done_o, go GAP; timeout counter starts at 0 on entry and increments each cycle.
REQ-027 WAIT_DONE: when counter reaches TIMEOUT with txempty_i still low, pulse err_o (not done_o), go GAP; txempty_i high in that same cycle SHALL take priority (done_o).
REQ-028 GAP: count GAP_CYCLES cycles, then IDLE; next pop no earlier than the cycle after IDLE entry.
REQ-029 Outside START, m_stb_o, m_we_o SHALL be 0; m_adr_o, m_dat_o, m_sel_o SHALL be 0.
REQ-030 busy_o SHALL be 1 in every state except IDLE; done_o and err_o SHALL never both be high.
REQ-031 count_o SHALL update the cycle after push/pop.

Reset
REQ-032 rst_i high SHALL immediately force IDLE, empty FIFO, counters 0, all outputs 0 except desc_ready_o=1.
REQ-033 Reset mid-START SHALL drop m_stb_o asynchronously; no done_o/err_o emitted; queued descriptors lost.
REQ-034 After rst_i falls, first push SHALL be accepted the next rising edge.

Verification
REQ-035 Push len=64, ack after 2 cycles, txempty_i low 3 cycles later then high after 100 -> one write adr 0 dat 0x40, done_o pulse, IDLE after 24 GAP cycles.
REQ-036 Push 5 descriptors with DEPTH=4 while first in flight -> desc_ready_o low at count_o=4, fifth held until pop, frames sent in push order.
REQ-037 txempty_i held low, TIMEOUT=100 -> err_o pulse exactly 100 cycles after WAIT_DONE entry, no done_o, next frame starts after gap.
REQ-038 Push len=0 -> no m_stb_o, done_o pulse, GAP entered.
REQ-039 Assert rst_i while m_stb_o high with 2 queued -> m_stb_o 0 same cycle, count_o 0, busy_o 0, no pulses.
REQ-040 txempty_i never drops (fast MAC) -> WAIT_BUSY exits after 16 cycles, done_o next cycle.
